// File: rtl/board_writer.sv
// -----------------------------------------------------------------------------
// board_writer
// Owns the 64-square board register. It is the only block that writes the
// packed bigBoard bus. Move requests arrive one at a time over a valid/ready
// handshake. Each request is checked against the side to move, then committed
// or rejected. The block also tracks the turn, pawn promotion and king capture.
//
// Ports:
//   clk         single clock; all logic runs on posedge
//   reset       synchronous, active-high; restores the start position
//   move_valid  a move request is present
//   move_ready  a request can be accepted (IDLE and game not over)
//   move_from   source square, index = row*8 + col
//   move_to     destination square
//   bigBoard    registered board, one nibble per square {colour, type[2:0]}
//   turn        side to move (0 = white, 1 = black)
//   move_done   one-cycle pulse: the move was committed
//   move_err    one-cycle pulse: the move was rejected, board unchanged
//   captured    nibble that was on move_to; held until the next commit
//   game_over   sticky; set when a king is captured, cleared only by reset
// -----------------------------------------------------------------------------
module board_writer (
    input  logic         clk,
    input  logic         reset,
    input  logic         move_valid,
    output logic         move_ready,
    input  logic [5:0]   move_from,
    input  logic [5:0]   move_to,
    output logic [255:0] bigBoard,
    output logic         turn,
    output logic         move_done,
    output logic         move_err,
    output logic [3:0]   captured,
    output logic         game_over
);

    // Start position. Each 32-bit word is one row with col 0 in the low
    // nibble. The top row is black (bit 3 set) and the bottom row is white.
    localparam logic [255:0] START_BOARD = {
        32'h42365324,   // row 7: R N B Q K B N R (white)
        32'h11111111,   // row 6: white pawns
        128'h0,         // rows 2..5: empty
        32'h99999999,   // row 1: black pawns
        32'hCABEDBAC    // row 0: r n b q k b n r (black)
    };

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REJECT} state_t;

    state_t         state_q, state_d;
    logic [255:0]   board_q, board_d;
    logic [5:0]     from_q, from_d;
    logic [5:0]     to_q, to_d;
    logic           turn_q, turn_d;
    logic           move_done_q, move_done_d;
    logic           move_err_q, move_err_d;
    logic [3:0]     captured_q, captured_d;
    logic           game_over_q, game_over_d;

    logic [3:0]     src;
    logic [3:0]     dst;
    logic [3:0]     placed;
    logic           illegal;

    // from_q/to_q are stable from CHECK through COMMIT. The board does not
    // change in between, so src/dst are the same value in both states.
    always_comb begin
        src = board_q[{from_q, 2'b00} +: 4];
        dst = board_q[{to_q, 2'b00} +: 4];

        illegal = (from_q == to_q)
                | (src[2:0] == 3'd0)
                | (src[2:0] == 3'd7)
                | (src[3] != turn_q)
                | ((dst[2:0] != 3'd0) && (dst[3] == src[3]));

        // A pawn that reaches the far row becomes a queen of the same colour.
        placed = src;
        if (src == 4'b0001 && to_q[5:3] == 3'd0) begin
            placed = 4'b0101;
        end else if (src == 4'b1001 && to_q[5:3] == 3'd7) begin
            placed = 4'b1101;
        end
    end

    assign move_ready = (state_q == IDLE) && !game_over_q;

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        from_d      = from_q;
        to_d        = to_q;
        turn_d      = turn_q;
        move_done_d = 1'b0;
        move_err_d  = 1'b0;
        captured_d  = captured_q;
        game_over_d = game_over_q;

        case (state_q)
            IDLE: begin
                if (move_valid && move_ready) begin
                    from_d  = move_from;
                    to_d    = move_to;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = illegal ? REJECT : COMMIT;
            end
            COMMIT: begin
                // Write both squares on the same edge so that bigBoard never
                // shows half of a move.
                board_d[{to_q, 2'b00} +: 4]   = placed;
                board_d[{from_q, 2'b00} +: 4] = 4'h0;
                captured_d  = dst;
                turn_d      = ~turn_q;
                if (dst[2:0] == 3'd6) begin
                    game_over_d = 1'b1;
                end
                move_done_d = 1'b1;
                state_d     = IDLE;
            end
            REJECT: begin
                move_err_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            board_q     <= START_BOARD;
            from_q      <= 6'd0;
            to_q        <= 6'd0;
            turn_q      <= 1'b0;
            move_done_q <= 1'b0;
            move_err_q  <= 1'b0;
            captured_q  <= 4'h0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            from_q      <= from_d;
            to_q        <= to_d;
            turn_q      <= turn_d;
            move_done_q <= move_done_d;
            move_err_q  <= move_err_d;
            captured_q  <= captured_d;
            game_over_q <= game_over_d;
        end
    end

    assign bigBoard  = board_q;
    assign turn      = turn_q;
    assign move_done = move_done_q;
    assign move_err  = move_err_q;
    assign captured  = captured_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_board_writer.sv
// -----------------------------------------------------------------------------
// tb_board_writer
// Self-checking bench for board_writer. Each request pushes its expected outcome
// (pulse kind, board, turn, captured, game_over) to a queue. The outcome comes
// from a small reference model. A monitor pops the queue and compares on every
// move_done/move_err pulse. Feature tasks add inline checks for reset state,
// timing, promotion, game over and reset during a move.
// -----------------------------------------------------------------------------
module tb_board_writer;

    localparam logic [255:0] START_BOARD = {
        32'h42365324, 32'h11111111, 128'h0, 32'h99999999, 32'hCABEDBAC
    };

    logic         clk;
    logic         reset;
    logic         move_valid;
    logic         move_ready;
    logic [5:0]   move_from;
    logic [5:0]   move_to;
    logic [255:0] bigBoard;
    logic         turn;
    logic         move_done;
    logic         move_err;
    logic [3:0]   captured;
    logic         game_over;

    board_writer dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_from  (move_from),
        .move_to    (move_to),
        .bigBoard   (bigBoard),
        .turn       (turn),
        .move_done  (move_done),
        .move_err   (move_err),
        .captured   (captured),
        .game_over  (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int           f;
        int           t;
        bit           done;
        logic [255:0] board;
        logic         turn;
        logic [3:0]   cap;
        logic         go;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [255:0] mb;
    logic         mturn;
    logic [3:0]   mcap;
    logic         mgo;

    function automatic logic [3:0] sq(input int i);
        return bigBoard[4*i +: 4];
    endfunction

    // Apply one request to the model and queue the expected outcome.
    task automatic model_push(input int f, input int t);
        logic [3:0] s;
        logic [3:0] d;
        logic [3:0] p;
        bit         rej;
        exp_t       e;
        s = mb[4*f +: 4];
        d = mb[4*t +: 4];
        rej = (f == t) || (s[2:0] == 3'd0) || (s[2:0] == 3'd7) || (s[3] != mturn)
              || ((d[2:0] != 3'd0) && (d[3] == s[3]));
        if (!rej) begin
            p = s;
            if (s == 4'h1 && (t / 8) == 0) p = 4'h5;
            if (s == 4'h9 && (t / 8) == 7) p = 4'hD;
            mb[4*t +: 4] = p;
            mb[4*f +: 4] = 4'h0;
            mcap  = d;
            mturn = ~mturn;
            if (d[2:0] == 3'd6) mgo = 1'b1;
        end
        e.f = f; e.t = t; e.done = !rej; e.board = mb;
        e.turn = mturn; e.cap = mcap; e.go = mgo;
        q.push_back(e);
    endtask

    // Scoreboard monitor: one line per completed transaction.
    always @(negedge clk) begin
        exp_t e;
        if (move_done || move_err) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b, required no pulse", move_done, move_err);
            end else begin
                e = q.pop_front();
                $display("txn %0d->%0d: done=%0b err=%0b turn=%0b captured=%h game_over=%0b",
                         e.f, e.t, move_done, move_err, turn, captured, game_over);
                if (move_done !== e.done || move_err !== !e.done) begin
                    errors++;
                    $display("FAIL pulse_kind %0d->%0d: done=%0b err=%0b, required done=%0b",
                             e.f, e.t, move_done, move_err, e.done);
                end
                checks++;
                if (bigBoard !== e.board) begin
                    errors++;
                    $display("FAIL board %0d->%0d: got %h required %h", e.f, e.t, bigBoard, e.board);
                end
                checks++;
                if (turn !== e.turn || captured !== e.cap || game_over !== e.go) begin
                    errors++;
                    $display("FAIL state %0d->%0d: turn=%0b cap=%h go=%0b required turn=%0b cap=%h go=%0b",
                             e.f, e.t, turn, captured, game_over, e.turn, e.cap, e.go);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        move_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mb = START_BOARD; mturn = 1'b0; mcap = 4'h0; mgo = 1'b0;
        q.delete();
    endtask

    // Wait for move_ready, present one request for one accepting edge, then
    // scramble the inputs (they may change freely after acceptance).
    task automatic send(input int f, input int t);
        int n = 0;
        @(negedge clk);
        while (!move_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!move_ready) begin
            errors++;
            $display("FAIL send_ready %0d->%0d: move_ready=%0b required 1", f, t, move_ready);
        end else begin
            move_valid = 1'b1;
            move_from = 6'(f);
            move_to = 6'(t);
            model_push(f, t);
            @(posedge clk);
            #1;
            move_valid = 1'b0;
            move_from = 6'($urandom_range(63));
            move_to = 6'($urandom_range(63));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d outstanding, required 0", q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (sq(0) !== 4'hC) begin errors++; $display("FAIL reset_sq0: %h required c", sq(0)); end
        checks++; if (sq(4) !== 4'hE) begin errors++; $display("FAIL reset_sq4: %h required e", sq(4)); end
        checks++; if (sq(60) !== 4'h6) begin errors++; $display("FAIL reset_sq60: %h required 6", sq(60)); end
        checks++; if (sq(52) !== 4'h1) begin errors++; $display("FAIL reset_sq52: %h required 1", sq(52)); end
        checks++; if (bigBoard !== START_BOARD) begin errors++; $display("FAIL reset_board: %h", bigBoard); end
        checks++;
        if (turn !== 1'b0 || move_ready !== 1'b1 || move_done !== 1'b0 || move_err !== 1'b0
            || captured !== 4'h0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: turn=%0b ready=%0b done=%0b err=%0b cap=%h go=%0b, required 0 1 0 0 0 0",
                     turn, move_ready, move_done, move_err, captured, game_over);
        end
    endtask

    task automatic test_rejections();
        send(12, 28);   // black piece on white's turn
        send(20, 28);   // empty source
        send(52, 52);   // from == to
        send(56, 57);   // rook onto own knight
        drain();
        checks++;
        if (bigBoard !== START_BOARD || turn !== 1'b0) begin
            errors++;
            $display("FAIL reject_unchanged: turn=%0b board=%h required start, turn 0", turn, bigBoard);
        end
    endtask

    task automatic test_quiet_move();
        logic r1, r2, d1, d2, d3, r3, d4;
        @(negedge clk);
        move_valid = 1'b1; move_from = 6'd52; move_to = 6'd36;
        model_push(52, 36);
        @(posedge clk); #1;
        move_valid = 1'b0;
        @(negedge clk); r1 = move_ready; d1 = move_done;
        @(negedge clk); r2 = move_ready; d2 = move_done;
        @(negedge clk); r3 = move_ready; d3 = move_done;
        checks++;
        if (r1 !== 1'b0 || r2 !== 1'b0 || r3 !== 1'b1) begin
            errors++;
            $display("FAIL quiet_ready: %0b%0b%0b required 001", r1, r2, r3);
        end
        checks++;
        if (d1 !== 1'b0 || d2 !== 1'b0 || d3 !== 1'b1) begin
            errors++;
            $display("FAIL quiet_done_timing: %0b%0b%0b required 001", d1, d2, d3);
        end
        checks++;
        if (sq(36) !== 4'h1 || sq(52) !== 4'h0 || turn !== 1'b1 || captured !== 4'h0) begin
            errors++;
            $display("FAIL quiet_result: sq36=%h sq52=%h turn=%0b cap=%h required 1 0 1 0",
                     sq(36), sq(52), turn, captured);
        end
        @(negedge clk); d4 = move_done;
        checks++;
        if (d4 !== 1'b0) begin errors++; $display("FAIL quiet_done_width: done=%0b required 0", d4); end
    endtask

    task automatic test_promotion();
        send(9, 25);    // black
        send(49, 17);   // white pawn
        send(8, 24);    // black
        send(17, 9);    // white pawn to row 1
        send(15, 31);   // black
        send(9, 0);     // white pawn takes rook on row 0
        drain();
        checks++;
        if (sq(0) !== 4'h5 || captured !== 4'hC || game_over !== 1'b0) begin
            errors++;
            $display("FAIL promotion: sq0=%h cap=%h go=%0b required 5 c 0", sq(0), captured, game_over);
        end
    endtask

    task automatic test_king_capture();
        int pulses = 0;
        send(14, 30);   // black
        send(0, 4);     // white queen takes black king
        drain();
        checks++;
        if (captured !== 4'hE || game_over !== 1'b1 || move_ready !== 1'b0) begin
            errors++;
            $display("FAIL king_capture: cap=%h go=%0b ready=%0b required e 1 0", captured, game_over, move_ready);
        end
        @(negedge clk);
        move_valid = 1'b1; move_from = 6'd14; move_to = 6'd22;
        repeat (10) begin
            @(negedge clk);
            if (move_done || move_err) pulses++;
        end
        move_valid = 1'b0;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL game_over_ignore: %0d pulses required 0", pulses); end
        do_reset();
        @(negedge clk);
        checks++;
        if (bigBoard !== START_BOARD || game_over !== 1'b0 || move_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_after_game_over: go=%0b ready=%0b board=%h", game_over, move_ready, bigBoard);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        move_valid = 1'b1; move_from = 6'd52; move_to = 6'd36;
        model_push(52, 36);
        @(posedge clk); #1;
        // Hold valid with the next request; it must wait for IDLE.
        move_from = 6'd12; move_to = 6'd28;
        model_push(12, 28);
        n = 0;
        do begin @(negedge clk); n++; end while (!move_done && n < 10);
        checks++;
        if (move_done !== 1'b1 || move_ready !== 1'b1 || n != 3) begin
            errors++;
            $display("FAIL b2b_first: done=%0b ready=%0b cycles=%0d required 1 1 3", move_done, move_ready, n);
        end
        @(posedge clk); #1;
        move_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!move_done && n < 10);
        checks++;
        if (move_done !== 1'b1 || n != 3) begin
            errors++;
            $display("FAIL b2b_second: done=%0b cycles=%0d required 1 3", move_done, n);
        end
        drain();
    endtask

    task automatic test_reset_mid_move();
        int pulses = 0;
        @(negedge clk);
        move_valid = 1'b1; move_from = 6'd48; move_to = 6'd32;
        @(posedge clk); #1;
        move_valid = 1'b0;
        reset = 1'b1;   // DUT is in CHECK this cycle
        @(posedge clk); #1;
        reset = 1'b0;
        mb = START_BOARD; mturn = 1'b0; mcap = 4'h0; mgo = 1'b0;
        q.delete();
        repeat (5) begin
            @(negedge clk);
            if (move_done || move_err) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL mid_reset_pulse: %0d pulses required 0", pulses); end
        checks++;
        if (bigBoard !== START_BOARD || turn !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: turn=%0b board=%h required start, turn 0", turn, bigBoard);
        end
    endtask

    initial begin
        reset = 1'b1;
        move_valid = 1'b0;
        move_from = 6'd0;
        move_to = 6'd0;
        mb = START_BOARD; mturn = 1'b0; mcap = 4'h0; mgo = 1'b0;
        test_reset();
        test_rejections();
        test_quiet_move();
        test_promotion();
        test_king_capture();
        test_back_to_back();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_writer.md
# board_writer

Owns the 64-square board register and is the single writer of the packed `bigBoard` bus that the move scanners read. It accepts one move request at a time over a valid/ready handshake, checks it against the side to move, and commits it: destination gets the moving piece, source is cleared, and any captured piece is reported. It also tracks turn, pawn promotion and king capture (game over). It sits between the move-selection/input logic and every board-reading block.

## Interface
Parameters: none. Encoding is fixed.
- Square index `i = row*8 + col`. Row 0 is the top (black home rank). Row 7 is the bottom (white home rank).
- Square nibble: `bigBoard[4*i+3 : 4*i]`. Bit 3 is colour (0 = white, 1 = black). Bits [2:0] are the type: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved.

Ports:
- `clk`  in  1: single clock, all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `move_valid`  in  1: request present.
- `move_ready`  out  1: block can accept a request.
- `move_from`  in  6: source square.
- `move_to`  in  6: destination square.
- `bigBoard`  out  256: registered board state.
- `turn`  out  1: side to move (0 = white).
- `move_done`  out  1: one-cycle pulse, move committed.
- `move_err`  out  1: one-cycle pulse, move rejected, board unchanged.
- `captured`  out  4: nibble formerly on `move_to`. Valid with `move_done`; holds until the next commit.
- `game_over`  out  1: sticky; a king was captured.

## Operation
- **Reset values:**
  - `bigBoard` = standard start position.
    - Row 0: C,A,B,D,E,B,A,C (hex nibbles, col 0..7).
    - Row 1: all 9.
    - Rows 2–5: all 0.
    - Row 6: all 1.
    - Row 7: 4,2,3,5,6,3,2,4.
  - `turn`=0, `move_done`=0, `move_err`=0, `captured`=0, `game_over`=0.
  - FSM state IDLE.
- **FSM states:** IDLE, CHECK, COMMIT, REJECT.
- **IDLE:**
  - `move_ready`=1 unless `game_over`.
  - On `move_valid & move_ready`, latch `move_from`/`move_to`, then go to CHECK.
- **CHECK:** read `src = board[from]` and `dst = board[to]`. The move is rejected if any of these holds:
  - `from == to`;
  - `src[2:0] == 0`;
  - `src[2:0] == 7`;
  - `src[3] != turn`;
  - `dst[2:0] != 0` and `dst[3] == src[3]` (own-piece capture).
  
  Otherwise go to COMMIT. Move geometry is not checked here; that belongs to the scanners.
- **COMMIT** (single cycle):
  - `board[to]` = src, except a pawn landing on its far row becomes a queen. White pawn on row 0 gives 0101; black pawn on row 7 gives 1101.
  - `board[from]` = 0.
  - `captured` = dst.
  - `turn` toggles.
  - If `dst[2:0] == 6`, `game_over` is set.
  - Pulse `move_done`, return to IDLE.
- **REJECT:** pulse `move_err`, return to IDLE. No change to board, turn or `captured`.
- **game_over:**
  - While set, `move_ready`=0.
  - Requests are ignored, not errored.
  - Only `reset` clears it.
- **Reset mid-operation:** reset dominates every state. The board returns to the start position, no pulse is emitted, and the latched request is discarded.
- **Inputs outside acceptance:** `move_valid` is ignored outside IDLE. `move_from`/`move_to` may change freely after acceptance.

## Timing
- Edge E0: request accepted (IDLE, valid & ready).
- Cycle after E0: state CHECK, `move_ready`=0.
- Edge E1: state becomes COMMIT or REJECT.
- Edge E2:
  - `bigBoard`, `turn`, `captured` and `game_over` update.
  - `move_done` or `move_err` is registered high for exactly the cycle after E2.
  - State returns to IDLE, so `move_ready`=1 in that same cycle (when not game over).
- Throughput: one move per 3 cycles. Latency from acceptance to a visible board update is 2 edges.
- Back-to-back: a request held valid during the done cycle is accepted at that edge.
- `bigBoard` never shows a partial move; from and to update on the same edge.

## Test plan
- **Reset:** after reset, `bigBoard[3:0]`=C, `bigBoard[19:16]`=E, square 60 = 6, square 52 = 1, `turn`=0, `move_ready`=1, all pulses 0.
- **Legal quiet move and timing:** from=52, to=36 (white pawn).
  - Two edges later: square 36 = 1, square 52 = 0, `turn`=1, `captured`=0.
  - `move_done` high exactly 1 cycle; `move_ready` low for exactly 2 cycles.
- **Rejections:** each leaves the board and `turn` unchanged, with `move_err` pulsing once.
  - from=12 while `turn`=0 (wrong colour).
  - from=20 (empty square).
  - from=to=52.
  - from=56, to=57 (own capture).
- **Capture and promotion:** preload by a move sequence so that a white pawn sits on square 9 and square 0 holds the black rook, then move 9->0.
  - Square 0 = 5 (queen), `captured`=C, `game_over`=0.
- **King capture:** a white piece takes the black king (dst=E).
  - `captured`=E, `game_over`=1, `move_ready`=0.
  - A following `move_valid` produces no pulse.
  - Reset restores the start position with `game_over`=0.
- **Reset mid-move:** assert `reset` in the CHECK cycle.
  - No `move_done`; board equals the start position; `turn`=0.
